// File: rtl/alu_issue.sv
// alu_issue: execute-issue stage feeding the RV32I ALU.
// Decodes funct3/funct7b5 into the ALU operation code, picks the register
// or immediate operands with the x0 rule, and holds the results in a
// 2-entry buffer (main + skid) whose head drives the ALU inputs directly.
// Optional feature macro: ALU_ISSUE_FWD_EN enables the writeback bypass.
// When it is undefined, the fwd_* ports are present but ignored.
module alu_issue #(
    parameter int OP_W  = 10,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_is_imm,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7b5,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [31:0]     in_rs1_val,
    input  logic [31:0]     in_rs2_val,
    input  logic [31:0]     in_imm,
    input  logic [4:0]      in_rd,
    input  logic            fwd_valid,
    input  logic [4:0]      fwd_rd,
    input  logic [31:0]     fwd_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     rs1_num,
    output logic [31:0]     rs2_num,
    output logic [OP_W-1:0] alu_op,
    output logic [4:0]      out_rd,
    output logic            err_illegal
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(10'd1);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(10'd2);
    localparam logic [OP_W-1:0] OP_SLL  = OP_W'(10'd3);
    localparam logic [OP_W-1:0] OP_SLT  = OP_W'(10'd5);
    localparam logic [OP_W-1:0] OP_SLTU = OP_W'(10'd6);
    localparam logic [OP_W-1:0] OP_XOR  = OP_W'(10'd7);
    localparam logic [OP_W-1:0] OP_SRL  = OP_W'(10'd8);
    localparam logic [OP_W-1:0] OP_SRA  = OP_W'(10'd9);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(10'd10);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(10'd11);

    // Map funct3/funct7b5 to the ALU operation code.
    function automatic logic [OP_W-1:0] decode_op(input logic is_imm,
                                                  input logic [2:0] f3,
                                                  input logic f7b5);
        logic [OP_W-1:0] op;
        case (f3)
            3'b000:  op = (!is_imm && f7b5) ? OP_SUB : OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = f7b5 ? OP_SRA : OP_SRL;
            3'b110:  op = OP_OR;
            3'b111:  op = OP_AND;
            default: op = OP_ADD;
        endcase
        return op;
    endfunction

    // funct7b5 is only meaningful for OP sub and for the right shifts.
    function automatic logic is_illegal(input logic is_imm,
                                        input logic [2:0] f3,
                                        input logic f7b5);
        logic bad;
        if (!f7b5) begin
            bad = 1'b0;
        end else if (f3 == 3'b101) begin
            bad = 1'b0;
        end else if ((f3 == 3'b000) && !is_imm) begin
            bad = 1'b0;
        end else begin
            bad = 1'b1;
        end
        return bad;
    endfunction

    logic            accept_s;
    logic            legal_s;
    logic            push_s;
    logic            pop_s;
    logic [1:0]      count_next_s;
    logic [31:0]     new_rs1_s;
    logic [31:0]     new_rs2_s;
    logic [OP_W-1:0] new_op_s;
    logic            hit_rs1_s;
    logic            hit_rs2_s;

    logic [1:0]      count_r;
    logic            out_valid_r;
    logic            in_ready_r;
    logic            err_r;
    logic [31:0]     head_rs1_r;
    logic [31:0]     head_rs2_r;
    logic [OP_W-1:0] head_op_r;
    logic [4:0]      head_rd_r;
    logic [31:0]     tail_rs1_r;
    logic [31:0]     tail_rs2_r;
    logic [OP_W-1:0] tail_op_r;
    logic [4:0]      tail_rd_r;

`ifdef ALU_ISSUE_FWD_EN
    // Writeback bypass match for each source index (x0 never matches).
    always_comb begin
        hit_rs1_s = fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == in_rs1);
        hit_rs2_s = fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == in_rs2);
    end
`else
    logic unused_fwd_s;

    // Bypass disabled: the bypass inputs are deliberately ignored.
    always_comb begin
        unused_fwd_s = ^{fwd_valid, fwd_rd, fwd_data};
        hit_rs1_s    = 1'b0;
        hit_rs2_s    = 1'b0;
    end
`endif

    // Decode the incoming instruction and form its operands.
    always_comb begin
        accept_s = in_valid && in_ready_r;
        legal_s  = !is_illegal(in_is_imm, in_funct3, in_funct7b5);
        push_s   = accept_s && legal_s;
        pop_s    = out_valid_r && out_ready;
        new_op_s = decode_op(in_is_imm, in_funct3, in_funct7b5);

        if (in_rs1 == 5'd0) begin
            new_rs1_s = 32'd0;
        end else if (hit_rs1_s) begin
            new_rs1_s = fwd_data;
        end else begin
            new_rs1_s = in_rs1_val;
        end

        if (in_is_imm) begin
            if ((in_funct3 == 3'b001) || (in_funct3 == 3'b101)) begin
                new_rs2_s = {27'd0, in_imm[4:0]};
            end else begin
                new_rs2_s = in_imm;
            end
        end else if (in_rs2 == 5'd0) begin
            new_rs2_s = 32'd0;
        end else if (hit_rs2_s) begin
            new_rs2_s = fwd_data;
        end else begin
            new_rs2_s = in_rs2_val;
        end
    end

    // Next occupancy from the push/pop pair.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + 2'd1;
            2'b01:   count_next_s = count_r - 2'd1;
            default: count_next_s = count_r;
        endcase
    end

    // Buffer state, handshake flags and the error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r     <= 2'd0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            err_r       <= 1'b0;
            head_rs1_r  <= 32'd0;
            head_rs2_r  <= 32'd0;
            head_op_r   <= '0;
            head_rd_r   <= 5'd0;
            tail_rs1_r  <= 32'd0;
            tail_rs2_r  <= 32'd0;
            tail_op_r   <= '0;
            tail_rd_r   <= 5'd0;
        end else begin
            count_r     <= count_next_s;
            out_valid_r <= (count_next_s != 2'd0);
            in_ready_r  <= (count_next_s != FULL);
            err_r       <= accept_s && !legal_s;
            case (count_r)
                2'd0: begin
                    if (push_s) begin
                        head_rs1_r <= new_rs1_s;
                        head_rs2_r <= new_rs2_s;
                        head_op_r  <= new_op_s;
                        head_rd_r  <= in_rd;
                    end
                end
                2'd1: begin
                    if (push_s && pop_s) begin
                        head_rs1_r <= new_rs1_s;
                        head_rs2_r <= new_rs2_s;
                        head_op_r  <= new_op_s;
                        head_rd_r  <= in_rd;
                    end else if (push_s) begin
                        tail_rs1_r <= new_rs1_s;
                        tail_rs2_r <= new_rs2_s;
                        tail_op_r  <= new_op_s;
                        tail_rd_r  <= in_rd;
                    end
                end
                2'd2: begin
                    if (pop_s) begin
                        head_rs1_r <= tail_rs1_r;
                        head_rs2_r <= tail_rs2_r;
                        head_op_r  <= tail_op_r;
                        head_rd_r  <= tail_rd_r;
                    end
                end
                default: begin
                    count_r <= 2'd0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign rs1_num     = head_rs1_r;
    assign rs2_num     = head_rs2_r;
    assign alu_op      = head_op_r;
    assign out_rd      = head_rd_r;
    assign err_illegal = err_r;

endmodule
